// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer.
// Direction counter encoding, FSM states, counter step function.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef enum logic {
    IDLE,
    CLEAR
  } bpState_t;

  function automatic ctr_t next_ctr(
    input ctr_t c,
    input logic taken
  );
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = c + 2'd1;
    end else begin
      if (c != SNT) n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with enable.
// Synchronous active-low reset.
module bp_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters,
// sequential table clear and perf counters.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             ex_mispredict,
  output logic [PC_W-1:0]  ex_redirect_pc,
  input  logic             clear_req,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  logic             validArr  [ENTRIES];
  logic [TAG_W-1:0] tagArr    [ENTRIES];
  logic [PC_W-1:0]  targetArr [ENTRIES];
  ctr_t             ctrArr    [ENTRIES];

  bpState_t         stateQ, stateD;
  logic [IDX_W-1:0] ptrQ, ptrD;

  logic [IDX_W-1:0] ifIdx, exIdx;
  logic [TAG_W-1:0] ifTag, exTag;
  logic             ifHit, exHit;
  logic             doUpd;

  assign ifIdx = if_pc[IDX_W-1:0];
  assign ifTag = if_pc[PC_W-1:IDX_W];
  assign exIdx = ex_pc[IDX_W-1:0];
  assign exTag = ex_pc[PC_W-1:IDX_W];

  assign ifHit = validArr[ifIdx] && (tagArr[ifIdx] == ifTag);
  assign exHit = validArr[exIdx] && (tagArr[exIdx] == exTag);

  assign busy        = (stateQ == CLEAR);
  assign pred_taken  = ifHit && ctrArr[ifIdx][1] && !busy;
  assign pred_target = pred_taken ? targetArr[ifIdx]
                                  : if_pc + PC_W'(1);

  always_comb begin
    ex_mispredict  = 1'b0;
    ex_redirect_pc = '0;
    if (ex_valid) begin
      if (ex_is_branch) begin
        ex_mispredict = (ex_pred_taken != ex_taken) ||
                        (ex_taken && (ex_pred_target != ex_target));
      end else begin
        ex_mispredict = ex_pred_taken;
      end
      ex_redirect_pc = (ex_is_branch && ex_taken) ? ex_target
                                                  : ex_pc + PC_W'(1);
    end
  end

  always_comb begin
    stateD = stateQ;
    ptrD   = ptrQ;
    unique case (stateQ)
      IDLE: begin
        if (clear_req) begin
          stateD = CLEAR;
          ptrD   = '0;
        end
      end
      CLEAR: begin
        ptrD = ptrQ + 1'b1;
        if (ptrQ == LAST) begin
          stateD = IDLE;
          ptrD   = '0;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ <= IDLE;
      ptrQ   <= '0;
    end else begin
      stateQ <= stateD;
      ptrQ   <= ptrD;
    end
  end

  assign doUpd = ex_valid && (stateQ == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validArr[i] <= 1'b0;
        ctrArr[i]   <= WNT;
      end
    end else if (stateQ == CLEAR) begin
      validArr[ptrQ] <= 1'b0;
      ctrArr[ptrQ]   <= WNT;
    end else if (doUpd) begin
      if (ex_is_branch) begin
        if (exHit) begin
          ctrArr[exIdx] <= next_ctr(ctrArr[exIdx], ex_taken);
        end else if (ex_taken) begin
          validArr[exIdx] <= 1'b1;
          ctrArr[exIdx]   <= WT;
        end
      end else if (ex_pred_taken) begin
        validArr[exIdx] <= 1'b0;
      end
    end
  end

  // Tags and targets carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (reset && doUpd && ex_is_branch && ex_taken) begin
      targetArr[exIdx] <= ex_target;
      if (!exHit) tagArr[exIdx] <= exTag;
    end
  end

  bp_sat_counter #(.CNT_W(CNT_W)) uBranchCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ex_valid && ex_is_branch),
    .count (branch_cnt)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) uMispredCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ex_mispredict),
    .count (mispredict_cnt)
  );

endmodule
